// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: shared state encoding and skid depth for the RAM stream reader
package ram_stream_reader_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/ram_stream_reader_skid.sv
// stream_skid_buffer: 2-entry FIFO with valid/ready read side and occupancy output
module stream_skid_buffer
    import ram_stream_reader_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    input  logic         ready,
    output logic [1:0]   occupancy
);
    logic [W-1:0] e0, e1;
    logic         pop;
    assign pop       = valid && ready;
    assign valid     = occupancy != 2'd0;
    assign dout      = e0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            e0        <= '0;
            e1        <= '0;
            occupancy <= 2'd0;
        end else begin
            occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
            if (push && (occupancy == 2'd0 || (occupancy == 2'd1 && pop)))
                e0 <= din;
            else if (pop && occupancy == 2'(SKID_DEPTH))
                e0 <= e1;
            if (push && ((occupancy == 2'd1 && !pop) || (occupancy == 2'd2 && pop)))
                e1 <= din;
        end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: sweeps a RAM read port and delivers words on a valid/ready stream
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10,
    parameter int WORDS = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [31:0]      count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      length,
    output logic [31:0]      raddress_b,
    input  logic [WIDTH-1:0] dout_b,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready
);
    state_t           state;
    logic [DEPTH-1:0] raddr;
    logic [31:0]      rem_issue;
    logic             inflight, inflight_last, issue;
    logic [1:0]       occ, pending;
    assign length     = 32'(WORDS);
    assign raddress_b = {{(32-DEPTH){1'b0}}, raddr};
    assign pending    = occ + {1'b0, inflight};
    // words already owed to the buffer must fit, counting the slot freed by a pop this cycle
    assign issue      = state == RUN && rem_issue != 32'd0 &&
                        (pending < 2'(SKID_DEPTH) || (m_valid && m_ready));
    stream_skid_buffer #(.W(WIDTH + 1)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .din       ({inflight_last, dout_b}),
        .dout      ({m_last, m_data}),
        .valid     (m_valid),
        .ready     (m_ready),
        .occupancy (occ)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            raddr         <= '0;
            rem_issue     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && rem_issue == 32'd1;
            if (issue) begin
                raddr     <= raddr + DEPTH'(1);
                rem_issue <= rem_issue - 32'd1;
            end
            case (state)
                IDLE:
                    if (start) begin
                        busy      <= 1'b1;
                        raddr     <= base_addr[DEPTH-1:0];
                        rem_issue <= count;
                        state     <= count == 32'd0 ? DONE : RUN;
                        done      <= count == 32'd0;
                    end
                RUN:
                    if (issue && rem_issue == 32'd1) state <= DRAIN;
                DRAIN:
                    if (m_valid && m_ready && m_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: scoreboard bench with a behavioural 1-cycle RAM
module tb_ram_stream_reader;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, m_ready = 1'b1;
    logic [31:0] base_addr = '0, count = '0;
    logic        busy, done, m_valid, m_last;
    logic [31:0] length, raddress_b, dout_b, m_data;
    logic [32:0] exp_q[$];
    logic [32:0] e;
    int          checks = 0, errors = 0, beats = 0, cyc = 0, b0;
    bit          rmode = 1'b0, hold_v = 1'b0, hold_l;
    logic [31:0] hold_d;

    ram_stream_reader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .length(length), .raddress_b(raddress_b), .dout_b(dout_b),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;
    // RAM content encodes its address so data order reveals the address sequence
    always @(posedge clk) dout_b <= 32'hA000_0000 | raddress_b;

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        m_ready = rmode ? (cyc % 3 == 0) : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (!reset) hold_v = 1'b0;
        else begin
            if (hold_v) begin
                checks++;
                if (!m_valid || m_data !== hold_d || m_last !== hold_l) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%h l=%0b, need v=1 d=%h l=%0b",
                             m_valid, m_data, m_last, hold_d, hold_l);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                beats++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got d=%h l=%0b, need no beat", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        errors++;
                        $display("FAIL beat: got d=%h l=%0b, need d=%h l=%0b", m_data, m_last, e[31:0], e[32]);
                    end
                end
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, need %h", name, act, req);
        end
    endtask

    task automatic start_xfer(input logic [31:0] b, input logic [31:0] n);
        base_addr = b;
        count     = n;
        start     = 1'b1;
        for (int i = 0; i < n; i++)
            exp_q.push_back({i == n - 1, 32'hA000_0000 | ((b + i) & 32'h3FF)});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    initial begin
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_valid", {31'b0, m_valid}, 0);
        chk("rst_last", {31'b0, m_last}, 0);
        chk("rst_raddr", raddress_b, 0);
        chk("rst_data", m_data, 0);
        chk("length", length, 32'd1024);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // basic latency, throughput and done timing
        start_xfer(32'h10, 4);
        chk("lat_e0", {31'b0, m_valid}, 0);
        @(posedge clk); #1;
        chk("lat_e1", {31'b0, m_valid}, 0);
        @(posedge clk); #1;
        chk("lat_e2", {31'b0, m_valid}, 1);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk("no_bubble", {31'b0, m_valid}, 1);
        end
        chk("last_flag", {31'b0, m_last}, 1);
        @(posedge clk); #1;
        chk("done_pulse", {31'b0, done}, 1);
        chk("valid_after", {31'b0, m_valid}, 0);
        @(posedge clk); #1;
        chk("busy_after", {31'b0, busy}, 0);
        chk("done_once", {31'b0, done}, 0);

        // backpressure 1,0,0 pattern
        rmode = 1'b1;
        start_xfer(32'h80, 8);
        wait_done();
        chk("bp_drained", exp_q.size(), 0);

        // address wrap
        rmode = 1'b0;
        @(posedge clk); #1;
        start_xfer(32'd1022, 4);
        wait_done();
        chk("wrap_drained", exp_q.size(), 0);

        // zero-length transfer
        @(posedge clk); #1;
        start_xfer(32'h55, 0);
        chk("zero_busy", {31'b0, busy}, 1);
        chk("zero_done", {31'b0, done}, 1);
        @(posedge clk); #1;
        chk("zero_busy_end", {31'b0, busy}, 0);
        chk("zero_done_end", {31'b0, done}, 0);
        chk("zero_valid", {31'b0, m_valid}, 0);

        // start while busy is ignored
        rmode = 1'b1;
        @(posedge clk); #1;
        start_xfer(32'h40, 4);
        repeat (2) begin @(posedge clk); #1; end
        base_addr = 32'h300;
        count     = 5;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (8) begin @(posedge clk); #1; end
        chk("ignore_drained", exp_q.size(), 0);
        chk("ignore_idle", {31'b0, busy}, 0);

        // reset mid-transfer after two beats
        rmode = 1'b0;
        b0 = beats;
        start_xfer(32'h100, 8);
        for (int k = 0; k < 50 && beats < b0 + 2; k++) begin @(posedge clk); #1; end
        chk("two_beats", beats - b0, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_busy", {31'b0, busy}, 0);
        chk("mid_valid", {31'b0, m_valid}, 0);
        chk("mid_last", {31'b0, m_last}, 0);
        chk("mid_raddr", raddress_b, 0);
        chk("mid_data", m_data, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", {31'b0, done}, 0);
        start_xfer(32'h200, 2);
        wait_done();
        chk("post_rst_drained", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
